// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register-access slave.
package spi_reg_pkg;

  typedef enum logic [1:0] {
    CMD = 2'd0,
    WR  = 2'd1,
    RD  = 2'd2
  } state_t;

  localparam int         CMD_RW_BIT     = 7;
  localparam logic [7:0] STATUS_DEFAULT = 8'hA5;

endpackage

// File: rtl/spi_reg_ctrl.sv
// SPI mode-0 slave translating command/data frames into register bank accesses.
// state | meaning
// CMD   | receiving command byte (held while cs_n=1)
// WR    | data bytes are written to reg_addr, address auto-increments
// RD    | data bytes return reg_rdata, address auto-increments
module spi_reg_ctrl
  import spi_reg_pkg::*;
#(
  parameter int              AW     = 7,
  parameter int              DW     = 8,
  parameter logic [DW-1:0]   STATUS = STATUS_DEFAULT
) (
  input  logic          sclk,
  input  logic          rst,
  input  logic          cs_n,
  input  logic          mosi,
  output logic          miso,
  output logic          miso_oe,
  output logic [AW-1:0] reg_addr,
  output logic [DW-1:0] reg_wdata,
  output logic          reg_we,
  input  logic [DW-1:0] reg_rdata
);

  state_t        state;
  logic [2:0]    bit_cnt;
  logic [DW-1:0] shift_in;
  logic [DW-1:0] shift_out;
  logic [DW-1:0] rx_byte;
  logic          frame_clr;
  logic          byte_end;

  // Deselect acts as a frame-level async clear so partial bytes never leak.
  assign frame_clr = rst | cs_n;
  assign rx_byte   = {shift_in[DW-2:0], mosi};
  assign byte_end  = (bit_cnt == 3'd7);

  always_ff @(posedge sclk or posedge frame_clr) begin
    if (frame_clr) begin
      state    <= CMD;
      bit_cnt  <= 3'd0;
      shift_in <= '0;
    end else begin
      shift_in <= rx_byte;
      bit_cnt  <= bit_cnt + 3'd1;
      if (byte_end && state == CMD)
        state <= rx_byte[CMD_RW_BIT] ? RD : WR;
    end
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      reg_addr <= '0;
    end else if (byte_end && !cs_n) begin
      if (state == CMD)
        reg_addr <= rx_byte[AW-1:0];
      else
        reg_addr <= reg_addr + AW'(1);
    end
  end

  // bit_cnt wraps to 0 on each 8th posedge, so the following negedge is the load slot.
  always_ff @(negedge sclk or posedge frame_clr) begin
    if (frame_clr)
      shift_out <= STATUS;
    else if (bit_cnt == 3'd0 && state == RD)
      shift_out <= reg_rdata;
    else
      shift_out <= {shift_out[DW-2:0], 1'b0};
  end

  assign miso      = shift_out[DW-1];
  assign miso_oe   = ~cs_n;
  assign reg_we    = (state == WR) && byte_end && !cs_n;
  assign reg_wdata = reg_we ? rx_byte : '0;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed plus randomized frames for spi_reg_ctrl, checked against a frame-level memory model.
module tb_spi_reg_ctrl;

  localparam int HALF = 5;
  localparam logic [7:0] STAT = 8'hA5;

  logic       sclk, rst, cs_n, mosi;
  logic       miso, miso_oe, reg_we;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata, reg_rdata;

  logic [7:0] bank      [128];
  logic [7:0] model_mem [128];

  logic [7:0] fq[$];
  logic [7:0] rx_q[$];
  logic [7:0] exp_rx[$];
  logic [6:0] cap_addr[$];
  logic [7:0] cap_data[$];
  logic [6:0] exp_wa[$];
  logic [7:0] exp_wd[$];
  logic [6:0] exp_end_addr;

  int n_pass = 0;
  int n_total = 0;

  spi_reg_ctrl dut (
    .sclk      (sclk),
    .rst       (rst),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .miso      (miso),
    .miso_oe   (miso_oe),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_rdata (reg_rdata)
  );

  assign reg_rdata = bank[reg_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Master side: drive mosi, sample miso mid-low-phase, capture writes before the posedge.
  task automatic send_bits(input logic [7:0] b, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i >= 8 - nbits; i--) begin
      mosi = b[i];
      #HALF;
      rx[i] = miso;
      if (reg_we === 1'b1) begin
        cap_addr.push_back(reg_addr);
        cap_data.push_back(reg_wdata);
        bank[reg_addr] = reg_wdata;
      end
      sclk = 1'b1;
      #HALF;
      sclk = 1'b0;
    end
  endtask

  task automatic model_frame();
    int a;
    bit rd;
    logic [7:0] c;
    exp_rx.delete(); exp_wa.delete(); exp_wd.delete();
    c  = fq[0];
    rd = c[7];
    a  = int'(c[6:0]);
    exp_rx.push_back(STAT);
    for (int i = 1; i < fq.size(); i++) begin
      int ad;
      ad = (a + i - 1) % 128;
      if (rd) begin
        exp_rx.push_back(model_mem[ad]);
      end else begin
        exp_rx.push_back(8'h00);
        exp_wa.push_back(7'(ad));
        exp_wd.push_back(fq[i]);
        model_mem[ad] = fq[i];
      end
    end
    exp_end_addr = 7'((a + fq.size() - 1) % 128);
  endtask

  task automatic run_frame(input string tag);
    logic [7:0] rx;
    model_frame();
    rx_q.delete(); cap_addr.delete(); cap_data.delete();
    cs_n = 1'b0;
    #HALF;
    check({tag, ".oe"}, miso_oe, 1);
    foreach (fq[i]) begin
      send_bits(fq[i], 8, rx);
      rx_q.push_back(rx);
    end
    #HALF;
    cs_n = 1'b1;
    #(2*HALF);
    for (int i = 0; i < exp_rx.size(); i++)
      check($sformatf("%s.miso%0d", tag, i), rx_q[i], exp_rx[i]);
    check({tag, ".wr_count"}, cap_addr.size(), exp_wa.size());
    if (cap_addr.size() == exp_wa.size()) begin
      for (int i = 0; i < exp_wa.size(); i++) begin
        check($sformatf("%s.wa%0d", tag, i), cap_addr[i], exp_wa[i]);
        check($sformatf("%s.wd%0d", tag, i), cap_data[i], exp_wd[i]);
      end
    end
    check({tag, ".end_addr"}, reg_addr, exp_end_addr);
    check({tag, ".idle_miso"}, miso, STAT[7]);
  endtask

  task automatic frame3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                        input string tag);
    fq.delete();
    fq.push_back(b0); fq.push_back(b1); fq.push_back(b2);
    run_frame(tag);
  endtask

  initial begin
    logic [7:0] rx;
    sclk = 1'b0; mosi = 1'b0; cs_n = 1'b1; rst = 1'b1;
    for (int i = 0; i < 128; i++) begin
      bank[i]      = 8'($urandom);
      model_mem[i] = bank[i];
    end
    #(3*HALF);
    check("rst.miso", miso, STAT[7]);
    check("rst.we", reg_we, 0);
    check("rst.wdata", reg_wdata, 0);
    check("rst.addr", reg_addr, 0);
    check("rst.oe", miso_oe, 0);
    rst = 1'b0;
    #(2*HALF);

    frame3(8'h05, 8'h3C, 8'h7E, "write");

    bank[16'h10] = 8'hAB; model_mem[16'h10] = 8'hAB;
    bank[16'h11] = 8'hCD; model_mem[16'h11] = 8'hCD;
    frame3(8'h90, 8'($urandom), 8'($urandom), "read");

    frame3(8'h7F, 8'h11, 8'h22, "wrap");

    // Abort after 5 bits of a data byte.
    cap_addr.delete(); cap_data.delete();
    cs_n = 1'b0;
    #HALF;
    send_bits(8'h02, 8, rx);
    check("abort.cmd_miso", rx, STAT);
    send_bits(8'h3C, 5, rx);
    #HALF;
    cs_n = 1'b1;
    #(2*HALF);
    check("abort.no_we", cap_addr.size(), 0);
    check("abort.idle_miso", miso, STAT[7]);
    fq.delete(); fq.push_back(8'h83); fq.push_back(8'($urandom));
    run_frame("after_abort");

    // Reset pulse after 3 bits of a data byte.
    cap_addr.delete(); cap_data.delete();
    cs_n = 1'b0;
    #HALF;
    send_bits(8'h0A, 8, rx);
    send_bits(8'hF0, 3, rx);
    rst = 1'b1;
    #1;
    check("midrst.we", reg_we, 0);
    check("midrst.wdata", reg_wdata, 0);
    check("midrst.miso", miso, STAT[7]);
    check("midrst.addr", reg_addr, 0);
    #HALF;
    rst = 1'b0;
    cs_n = 1'b1;
    #(2*HALF);
    check("midrst.no_we", cap_addr.size(), 0);
    fq.delete(); fq.push_back(8'h01); fq.push_back(8'h55);
    run_frame("after_rst");

    // Partial command byte must leave no trace.
    cap_addr.delete(); cap_data.delete();
    cs_n = 1'b0;
    #HALF;
    send_bits(8'h85, 4, rx);
    #HALF;
    cs_n = 1'b1;
    #(2*HALF);
    check("pcmd.no_we", cap_addr.size(), 0);
    check("pcmd.addr", reg_addr, exp_end_addr);

    for (int f = 0; f < 8; f++) begin
      int n;
      fq.delete();
      fq.push_back(8'($urandom));
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) fq.push_back(8'($urandom));
      run_frame($sformatf("rnd%0d", f));
    end

    for (int i = 0; i < 128; i++)
      if (bank[i] !== model_mem[i]) check($sformatf("bank%0d", i), bank[i], model_mem[i]);
    check("bank.sample", bank[16'h05], model_mem[16'h05]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
